// File: rtl/xx6812_strip_encoder_pkg.sv
// xx6812_strip_encoder_pkg: shared state encodings, segment indices and segment level helper
package xx6812_strip_encoder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, LATCH = 2'd3} state_t;
    localparam logic [1:0] SEG_HIGH = 2'd0;
    localparam logic [1:0] SEG_DATA = 2'd1;
    localparam logic [1:0] SEG_LAST = 2'd3;
    localparam int DEFAULT_LATCH_SEGMENTS = 240;
    function automatic logic seg_level(input logic [1:0] seg, input logic msb);
        return seg == SEG_HIGH || (seg == SEG_DATA && msb);
    endfunction
endpackage

// File: rtl/xx6812_pixel_shifter.sv
// xx6812_pixel_shifter: shifts one pixel out MSB first as four segments per bit
module xx6812_pixel_shifter
    import xx6812_strip_encoder_pkg::*;
#(
    parameter int BITS_PER_LED = 24
) (
    input  logic                    clock_3mhz,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic                    run,
    input  logic [BITS_PER_LED-1:0] pixel_data,
    output logic                    level,
    output logic                    last_segment_of_pixel
);
    localparam int BW = $clog2(BITS_PER_LED);
    logic [BITS_PER_LED-1:0] shift_reg, shift_next;
    logic [BW-1:0] bit_cnt, bit_next;
    logic [1:0] seg, seg_next;
    logic wrap, level_next;
    always_comb begin
        last_segment_of_pixel = seg == SEG_LAST && bit_cnt == '0;
        wrap = run && seg == SEG_LAST && bit_cnt != '0;
        shift_next = load ? pixel_data : wrap ? shift_reg << 1 : shift_reg;
        bit_next = load ? BW'(BITS_PER_LED - 1) : wrap ? bit_cnt - 1'b1 : bit_cnt;
        seg_next = load ? SEG_HIGH : run ? seg + 2'd1 : seg;
        // level is registered one cycle ahead so the pin follows the segment with no extra latency
        level_next = (load || (run && !last_segment_of_pixel)) && seg_level(seg_next, shift_next[BITS_PER_LED-1]);
    end
    always_ff @(posedge clock_3mhz or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            bit_cnt <= '0;
            seg <= '0;
            level <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            bit_cnt <= bit_next;
            seg <= seg_next;
            level <= level_next;
        end
    end
endmodule

// File: rtl/xx6812_strip_encoder.sv
// xx6812_strip_encoder: serialises a strip frame into xx6812 one-wire format, then holds the latch low period
module xx6812_strip_encoder
    import xx6812_strip_encoder_pkg::*;
#(
    parameter int BITS_PER_LED = 24,
    parameter int LED_COUNT = 60,
    parameter int LATCH_SEGMENTS = DEFAULT_LATCH_SEGMENTS,
    localparam int IW = LED_COUNT > 1 ? $clog2(LED_COUNT) : 1
) (
    input  logic                    clock_3mhz,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [BITS_PER_LED-1:0] pixel_data,
    input  logic                    pixel_valid,
    output logic                    pixel_ready,
    output logic [IW-1:0]           pixel_index,
    output logic                    serial_data_out,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    underrun
);
    localparam int PW = $clog2(LED_COUNT + 1);
    localparam int LW = $clog2(LATCH_SEGMENTS + 1);
    state_t state;
    logic [PW-1:0] pixel_cnt;
    logic [LW-1:0] latch_cnt;
    logic last_seg, send_end, remain, handshake;
    always_comb begin
        remain = pixel_cnt != PW'(LED_COUNT);
        send_end = state == SEND && last_seg;
        pixel_ready = state == LOAD || (send_end && remain);
        handshake = pixel_ready && pixel_valid;
    end
    xx6812_pixel_shifter #(.BITS_PER_LED(BITS_PER_LED)) u_shifter (
        .clock_3mhz(clock_3mhz),
        .reset_n(reset_n),
        .load(handshake),
        .run(state == SEND),
        .pixel_data(pixel_data),
        .level(serial_data_out),
        .last_segment_of_pixel(last_seg)
    );
    always_ff @(posedge clock_3mhz or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy <= 1'b0;
            frame_done <= 1'b0;
            underrun <= 1'b0;
            pixel_index <= '0;
            pixel_cnt <= '0;
            latch_cnt <= '0;
        end else begin
            frame_done <= 1'b0;
            underrun <= 1'b0;
            if (handshake) begin
                pixel_cnt <= pixel_cnt + 1'b1;
                if (pixel_cnt != PW'(LED_COUNT - 1)) pixel_index <= pixel_index + 1'b1;
            end
            case (state)
                IDLE: if (start && !frame_done) begin
                    state <= LOAD;
                    busy <= 1'b1;
                    pixel_index <= '0;
                    pixel_cnt <= '0;
                end
                LOAD: if (handshake) state <= SEND;
                SEND: if (send_end && !handshake) begin
                    // a missing pixel at its slot aborts the rest of the frame
                    state <= LATCH;
                    latch_cnt <= '0;
                    underrun <= remain;
                end
                LATCH: if (latch_cnt == LW'(LATCH_SEGMENTS - 1)) begin
                    state <= IDLE;
                    frame_done <= 1'b1;
                    busy <= 1'b0;
                end else latch_cnt <= latch_cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xx6812_strip_encoder.sv
// tb_xx6812_strip_encoder: directed and random frames on three encoder configurations against a waveform model
module tb_xx6812_strip_encoder;
    logic clock_3mhz = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic valid = 1'b0;
    logic [31:0] data = '0;
    int sel = 0;
    logic [2:0] rdy, ser, bsy, dn, ur;
    logic [1:0] idx_a;
    logic idx_b, idx_c;
    logic ser_m, rdy_m, bsy_m, dn_m, ur_m;
    int idx_m;
    int npix [3] = '{3, 2, 1};
    int nbits [3] = '{24, 32, 24};
    int nlat [3] = '{240, 7, 240};
    logic [31:0] pix [4];
    logic [31:0] last_head;
    int tests = 0;
    int fails = 0;

    always #5 clock_3mhz = ~clock_3mhz;

    xx6812_strip_encoder #(.BITS_PER_LED(24), .LED_COUNT(3), .LATCH_SEGMENTS(240)) u_a (
        .clock_3mhz(clock_3mhz), .reset_n(reset_n), .start(start && sel == 0),
        .pixel_data(data[23:0]), .pixel_valid(valid), .pixel_ready(rdy[0]), .pixel_index(idx_a),
        .serial_data_out(ser[0]), .busy(bsy[0]), .frame_done(dn[0]), .underrun(ur[0]));
    xx6812_strip_encoder #(.BITS_PER_LED(32), .LED_COUNT(2), .LATCH_SEGMENTS(7)) u_b (
        .clock_3mhz(clock_3mhz), .reset_n(reset_n), .start(start && sel == 1),
        .pixel_data(data), .pixel_valid(valid), .pixel_ready(rdy[1]), .pixel_index(idx_b),
        .serial_data_out(ser[1]), .busy(bsy[1]), .frame_done(dn[1]), .underrun(ur[1]));
    xx6812_strip_encoder #(.BITS_PER_LED(24), .LED_COUNT(1), .LATCH_SEGMENTS(240)) u_c (
        .clock_3mhz(clock_3mhz), .reset_n(reset_n), .start(start && sel == 2),
        .pixel_data(data[23:0]), .pixel_valid(valid), .pixel_ready(rdy[2]), .pixel_index(idx_c),
        .serial_data_out(ser[2]), .busy(bsy[2]), .frame_done(dn[2]), .underrun(ur[2]));

    always_comb begin
        ser_m = ser[sel];
        rdy_m = rdy[sel];
        bsy_m = bsy[sel];
        dn_m = dn[sel];
        ur_m = ur[sel];
        idx_m = sel == 0 ? int'(idx_a) : sel == 1 ? int'(idx_b) : int'(idx_c);
    end

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h (sel %0d, t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " serial"}, int'(ser_m), 0);
        chk({tag, " ready"}, int'(rdy_m), 0);
        chk({tag, " busy"}, int'(bsy_m), 0);
        chk({tag, " done"}, int'(dn_m), 0);
        chk({tag, " underrun"}, int'(ur_m), 0);
        chk({tag, " index"}, idx_m, 0);
    endtask

    task automatic fill_random(input logic [31:0] mask);
        for (int i = 0; i < 4; i++) pix[i] = $urandom() & mask;
    endtask

    // One frame on instance sel: load_delay cycles without valid, optional missing pixel drop_at
    task automatic frame(input int d, input int drop_at, input bit poke);
        int n, b, l, s, cd, k, first, done_at, last_hs, o;
        logic e_ser, e_rdy;
        logic [31:0] head;
        n = npix[sel]; b = nbits[sel]; l = nlat[sel];
        s = (drop_at > 0 && drop_at < n) ? drop_at : n;
        cd = d + 1 + 4 * b * s + l;
        k = 0; first = -1; done_at = -1; last_hs = -1; head = '0;
        @(negedge clock_3mhz);
        start = 1'b1; valid = d == 0; data = pix[0];
        for (int c = 0; c <= cd; c++) begin
            @(negedge clock_3mhz);
            start = poke && (c == d + 50 || c == cd);
            valid = c >= d && !(drop_at > 0 && k == drop_at);
            data = pix[k < 4 ? k : 3];
            o = c - d - 1;
            e_ser = 1'b0;
            if (o >= 0 && o < 4 * b * s)
                e_ser = o % 4 == 0 ? 1'b1 : o % 4 == 1 ? pix[o / (4 * b)][b - 1 - (o % (4 * b)) / 4] : 1'b0;
            e_rdy = c <= d || (c <= d + 4 * b * s && (c - d) % (4 * b) == 0 && (c - d) / (4 * b) < n);
            chk("serial", int'(ser_m), int'(e_ser));
            chk("pixel_ready", int'(rdy_m), int'(e_rdy));
            chk("underrun", int'(ur_m), int'(s < n && c == d + 1 + 4 * b * s));
            chk("frame_done", int'(dn_m), int'(c == cd));
            chk("busy", int'(bsy_m), int'(c < cd));
            if (ser_m && first < 0) first = c;
            if (dn_m && done_at < 0) done_at = c;
            if (c >= d + 1 && c < d + 33) head = {head[30:0], ser_m};
            if (rdy_m && valid) begin
                chk("pixel_index", idx_m, k);
                if (last_hs >= 0) chk("handshake gap", c - last_hs, 4 * b);
                last_hs = c;
                k++;
            end
        end
        start = 1'b0;
        valid = 1'b0;
        chk("first seg0", first, d + 1);
        chk("frame length", done_at - first, 4 * b * s + l);
        chk("handshakes", k, s);
        last_head = head;
    endtask

    initial begin
        repeat (3) @(negedge clock_3mhz);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1 check_quiet("reset");
        end
        reset_n = 1'b1;
        sel = 0;
        fill_random(32'h00FF_FFFF);
        @(negedge clock_3mhz);
        start = 1'b1; valid = 1'b1; data = pix[0];
        @(negedge clock_3mhz);
        start = 1'b0;
        @(negedge clock_3mhz);
        chk("mid-send serial high", int'(ser_m), 1);
        chk("mid-send busy", int'(bsy_m), 1);
        reset_n = 1'b0;
        #1 chk("async reset serial", int'(ser_m), 0);
        chk("async reset busy", int'(bsy_m), 0);
        valid = 1'b0;
        repeat (2) @(negedge clock_3mhz);
        reset_n = 1'b1;
        repeat (2) @(negedge clock_3mhz);
        check_quiet("after reset");

        sel = 2;
        pix[0] = 32'h00A5_0000;
        frame(0, 0, 1'b0);
        chk("0xA50000 first byte", int'(last_head), int'(32'hC8C8_8C8C));

        sel = 0;
        fill_random(32'h00FF_FFFF);
        frame(0, 0, 1'b0);
        frame(3, 0, 1'b0);
        frame(0, 1, 1'b0);
        frame(2, 2, 1'b0);

        sel = 1;
        for (int i = 0; i < 4; i++) pix[i] = 32'hFFFF_FFFF;
        frame(0, 0, 1'b0);
        chk("rgbw all ones head", int'(last_head), int'(32'hCCCC_CCCC));
        fill_random(32'hFFFF_FFFF);
        frame(1, 1, 1'b0);

        sel = 0;
        fill_random(32'h00FF_FFFF);
        frame(0, 0, 1'b1);
        frame(0, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            sel = $urandom_range(0, 2);
            fill_random(32'hFFFF_FFFF);
            frame($urandom_range(0, 4), $urandom_range(0, npix[sel] - 1), r[0]);
        end
        @(negedge clock_3mhz);
        check_quiet("final idle");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
